// File: rtl/flag_pkg.sv
// Shared definitions for the ALU flag consumer: condition-code values, flag bit
// positions, result-register states and the condition evaluation function.
package flag_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_e;

  // NV is reserved and never taken, but it still produces a result.
  function automatic logic cond_true(input logic [3:0] code, input logic [3:0] nzcv);
    logic n, z, c, v, result;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    result = 1'b0;
    case (code)
      COND_EQ: result = z;
      COND_NE: result = ~z;
      COND_CS: result = c;
      COND_CC: result = ~c;
      COND_MI: result = n;
      COND_PL: result = ~n;
      COND_VS: result = v;
      COND_VC: result = ~v;
      COND_HI: result = c & ~z;
      COND_LS: result = ~c | z;
      COND_GE: result = (n == v);
      COND_LT: result = (n != v);
      COND_GT: result = ~z & (n == v);
      COND_LE: result = z | (n != v);
      COND_AL: result = 1'b1;
      COND_NV: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator; shared with the predication logic so
// that branches and predicated instructions agree on every code.
module cond_eval
  import flag_pkg::*;
(
  input  logic [3:0] cond_code,
  input  logic [3:0] nzcv,
  output logic       taken
);

  assign taken = cond_true(cond_code, nzcv);

endmodule

// File: rtl/flag_cond_unit.sv
// NZCV flag register plus condition evaluation with a one-deep registered result.
// Optional macro FLAG_FORWARD_EN bypasses same-cycle flag writes instead of stalling.
module flag_cond_unit
  import flag_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_wr_en,
  input  logic [3:0]       flag_in,
  input  logic             cond_valid,
  input  logic [3:0]       cond_code,
  input  logic [TAG_W-1:0] cond_tag,
  output logic             cond_ready,
  output logic             res_valid,
  output logic             res_taken,
  output logic [TAG_W-1:0] res_tag,
  input  logic             res_ready,
  output logic [3:0]       flags_q
);

  res_state_e       state_q, state_d;
  logic             res_taken_q;
  logic [TAG_W-1:0] res_tag_q;
  logic [3:0]       eval_flags;
  logic             stall;
  logic             accept;
  logic             taken;

`ifdef FLAG_FORWARD_EN
  assign stall      = 1'b0;
  assign eval_flags = flag_wr_en ? flag_in : flags_q;
`else
  // Hold the request off one cycle so it is evaluated against the newly written flags.
  assign stall      = flag_wr_en & cond_valid;
  assign eval_flags = flags_q;
`endif

  assign res_valid  = (state_q == RES_FULL);
  assign cond_ready = (~res_valid | res_ready) & ~stall;
  assign accept     = cond_valid & cond_ready;
  assign res_taken  = res_taken_q;
  assign res_tag    = res_tag_q;

  cond_eval u_cond_eval (
    .cond_code (cond_code),
    .nzcv      (eval_flags),
    .taken     (taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (flag_wr_en) begin
      flags_q <= flag_in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RES_EMPTY: if (accept) state_d = RES_FULL;
      RES_FULL:  if (res_ready && !accept) state_d = RES_EMPTY;
      default:   state_d = RES_EMPTY;
    endcase
  end

  // Payload only moves on accept, so it stays frozen while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RES_EMPTY;
      res_taken_q <= 1'b0;
      res_tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        res_taken_q <= taken;
        res_tag_q   <= cond_tag;
      end
    end
  end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Scoreboard bench for flag_cond_unit: driver pushes expected results from a
// behavioural model, an independent monitor pops and compares on each handoff.
module tb_flag_cond_unit;

  localparam int TAG_W = 4;

  typedef struct {
    logic             taken;
    logic [TAG_W-1:0] tag;
  } expT;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flag_wr_en = 1'b0;
  logic [3:0]       flag_in = 4'h0;
  logic             cond_valid = 1'b0;
  logic [3:0]       cond_code = 4'h0;
  logic [TAG_W-1:0] cond_tag = '0;
  logic             cond_ready;
  logic             res_valid;
  logic             res_taken;
  logic [TAG_W-1:0] res_tag;
  logic             res_ready = 1'b1;
  logic [3:0]       flags_q;

  int   totalChecks = 0;
  int   badChecks = 0;
  expT  sb[$];
  logic [3:0] flagsModel = 4'h0;

  flag_cond_unit #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flag_wr_en (flag_wr_en),
    .flag_in    (flag_in),
    .cond_valid (cond_valid),
    .cond_code  (cond_code),
    .cond_tag   (cond_tag),
    .cond_ready (cond_ready),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .res_tag    (res_tag),
    .res_ready  (res_ready),
    .flags_q    (flags_q)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference truth of a condition, written from the flag meanings directly.
  function automatic logic refTaken(input logic [3:0] code, input logic [3:0] f);
    bit n = f[3], z = f[2], c = f[1], v = f[0];
    bit signedLess = (n ^ v);
    case (code)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !(c && !z);
      4'hA: return !signedLess;
      4'hB: return signedLess;
      4'hC: return !z && !signedLess;
      4'hD: return z || signedLess;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // The unit holds at most one result: it can take a request only when none is left behind.
  task automatic applyStimulus(input logic wr, input logic [3:0] fin, input logic valid,
                               input logic [3:0] code, input logic [TAG_W-1:0] tag,
                               input logic rr, output logic accepted);
    logic stall, expReady;
    logic [3:0] evalF;
    flag_wr_en = wr;
    flag_in    = fin;
    cond_valid = valid;
    cond_code  = code;
    cond_tag   = tag;
    res_ready  = rr;
    @(negedge clk);
    #1;
`ifdef FLAG_FORWARD_EN
    stall = 1'b0;
    evalF = wr ? fin : flagsModel;
`else
    stall = wr && valid;
    evalF = flagsModel;
`endif
    expReady = (sb.size() == 0) && !stall;
    checkOutput("cond_ready", {31'b0, cond_ready}, {31'b0, expReady});
    checkOutput("flags_q", {28'b0, flags_q}, {28'b0, flagsModel});
    @(posedge clk);
    accepted = valid && expReady;
    if (accepted) sb.push_back('{taken: refTaken(code, evalF), tag: tag});
    if (wr) flagsModel = fin;
    #1;
  endtask

  task automatic applyRequest(input logic wr, input logic [3:0] fin, input logic [3:0] code,
                              input logic [TAG_W-1:0] tag);
    logic acc = 1'b0;
    applyStimulus(wr, fin, 1'b1, code, tag, 1'b1, acc);
    for (int i = 0; i < 8 && !acc; i++)
      applyStimulus(1'b0, fin, 1'b1, code, tag, 1'b1, acc);
    checkOutput("request_accepted", {31'b0, acc}, 32'd1);
  endtask

  task automatic idle(input int n, input logic rr);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, '0, rr, acc);
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    flag_wr_en = 1'b0;
    cond_valid = 1'b0;
    #1;
    checkOutput("reset_res_valid", {31'b0, res_valid}, 32'd0);
    checkOutput("reset_flags", {28'b0, flags_q}, 32'd0);
    sb.delete();
    flagsModel = 4'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: a result leaves at the next rising edge whenever valid and ready are both high here.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("res_valid", {31'b0, res_valid}, {31'b0, (sb.size() != 0)});
      if (res_valid && sb.size() != 0) begin
        checkOutput("res_taken", {31'b0, res_taken}, {31'b0, sb[0].taken});
        checkOutput("res_tag", {28'b0, res_tag}, {28'b0, sb[0].tag});
        if (res_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic acc;
    logic [3:0] nzcv8 = 4'b1000;
    logic [3:0] codes8 [8] = '{4'hB, 4'hA, 4'hD, 4'hC, 4'h3, 4'h8, 4'hE, 4'hF};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("init_flags", {28'b0, flags_q}, 32'd0);
    checkOutput("init_res_valid", {31'b0, res_valid}, 32'd0);
    checkOutput("init_res_taken", {31'b0, res_taken}, 32'd0);
    checkOutput("init_res_tag", {28'b0, res_tag}, 32'd0);
    rst_n = 1'b1;
    idle(1, 1'b1);

    $display("[TB] EQ/NE with Z set");
    applyStimulus(1'b1, 4'b0100, 1'b0, 4'h0, '0, 1'b1, acc);
    applyRequest(1'b0, 4'h0, 4'h0, 4'd3);
    applyRequest(1'b0, 4'h0, 4'h1, 4'd4);
    idle(2, 1'b1);

    $display("[TB] signed/unsigned codes with N only");
    applyStimulus(1'b1, nzcv8, 1'b0, 4'h0, '0, 1'b1, acc);
    for (int i = 0; i < 8; i++) applyRequest(1'b0, 4'h0, codes8[i], 4'(i + 5));
    idle(2, 1'b1);

    $display("[TB] backpressure");
    applyRequest(1'b0, 4'h0, 4'hE, 4'd9);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'h0, 1'b1, 4'h4, 4'd10, 1'b0, acc);
    applyRequest(1'b0, 4'h0, 4'h4, 4'd10);
    idle(2, 1'b1);

    $display("[TB] same-cycle flag write hazard");
    applyStimulus(1'b1, 4'b0000, 1'b0, 4'h0, '0, 1'b1, acc);
    applyRequest(1'b1, 4'b0010, 4'h2, 4'd11);
    idle(2, 1'b1);

    $display("[TB] streaming all codes with mid-stream reset");
    applyStimulus(1'b1, 4'b0110, 1'b0, 4'h0, '0, 1'b1, acc);
    for (int i = 0; i < 16; i++) begin
      if (i == 9) begin
        pulseReset();
        applyStimulus(1'b1, 4'b1011, 1'b0, 4'h0, '0, 1'b1, acc);
      end
      applyRequest(1'b0, 4'h0, 4'(i), 4'(i));
    end
    idle(2, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 3) == 0), 4'($urandom), 1'($urandom),
                    4'($urandom), TAG_W'($urandom), 1'($urandom_range(0, 3) != 0), acc);

    idle(4, 1'b1);
    checkOutput("drain_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
